// File: rtl/ecc_secded_wr_pipe.sv
// ecc_secded_wr_pipe
// Write-path encoder between the FIFO write port and the ECC-protected memory.
// It takes a byte-addressed write request, computes a Hamming SECDED
// codeword from the write data and presents it to the memory. Two register
// stages are used, with a valid/ready handshake that carries backpressure
// from the memory back to the requester. An optional error-injection mode
// flips codeword bits for verification, and a counter tracks completed writes.
//
// Ports:
//   clk_i         rising-edge clock
//   rst_n_i       asynchronous active-low reset
//   wr_valid_i    write request valid
//   wr_ready_o    block can accept a request this cycle
//   wr_addr_i     byte address (bits [1:0] ignored)
//   data_in       write data
//   inj_mode_i    00/11 none, 01 flip one bit, 10 flip two adjacent bits
//   inj_pos_i     codeword bit to flip
//   wr_en_o       codeword valid towards memory
//   mem_ready_i   memory accepts the codeword this cycle
//   wr_addr_o     memory word address
//   encoded_data  codeword {check bits, overall parity, data}
//   wr_count_o    number of completed writes, wraps
module ecc_secded_wr_pipe #(
  parameter int DATA_WIDTH        = 32,
  parameter int PARITY_BITS       = 6,
  parameter int MEMORY_DATA_WIDTH = DATA_WIDTH + PARITY_BITS + 1,
  parameter int ADDR_IN_WIDTH     = 32,
  parameter int ADDR_WIDTH        = 5,
  parameter int CNT_WIDTH         = 16
) (
  input  logic                                 clk_i,
  input  logic                                 rst_n_i,
  input  logic                                 wr_valid_i,
  output logic                                 wr_ready_o,
  input  logic [ADDR_IN_WIDTH-1:0]             wr_addr_i,
  input  logic [DATA_WIDTH-1:0]                data_in,
  input  logic [1:0]                           inj_mode_i,
  input  logic [$clog2(MEMORY_DATA_WIDTH)-1:0] inj_pos_i,
  output logic                                 wr_en_o,
  input  logic                                 mem_ready_i,
  output logic [ADDR_WIDTH-1:0]                wr_addr_o,
  output logic [MEMORY_DATA_WIDTH-1:0]         encoded_data,
  output logic [CNT_WIDTH-1:0]                 wr_count_o
);

  localparam int POS_WIDTH = $clog2(MEMORY_DATA_WIDTH);

  // The check bits taken together equal the XOR of the Hamming positions of
  // every set data bit; bit k-1 of that value is check bit p[k]. Data bits
  // occupy the non-power-of-two positions in ascending order from position 3.
  function automatic logic [MEMORY_DATA_WIDTH-1:0] encodeWord(input logic [DATA_WIDTH-1:0] d);
    logic [PARITY_BITS-1:0] syn;
    logic [DATA_WIDTH-1:0]  rest;
    logic                   overall;
    syn  = '0;
    rest = d;
    for (int hp = 3; hp <= DATA_WIDTH + PARITY_BITS; hp++) begin
      if ((hp & (hp - 1)) != 0) begin
        if (rest[0]) begin
          syn = syn ^ hp[PARITY_BITS-1:0];
        end
        rest = rest >> 1;
      end
    end
    overall = (^d) ^ (^syn);
    return {syn, overall, d};
  endfunction

  // An out-of-range position disables injection entirely; the second bit of
  // a double flip wraps from the top codeword bit back to bit 0.
  function automatic logic [MEMORY_DATA_WIDTH-1:0] injectErrors(
    input logic [MEMORY_DATA_WIDTH-1:0] cw,
    input logic [1:0]                   mode,
    input logic [POS_WIDTH-1:0]         pos
  );
    logic [MEMORY_DATA_WIDTH-1:0] one;
    logic [MEMORY_DATA_WIDTH-1:0] mask;
    int first;
    int second;
    one    = {{(MEMORY_DATA_WIDTH-1){1'b0}}, 1'b1};
    mask   = '0;
    first  = int'(pos);
    second = (first == MEMORY_DATA_WIDTH - 1) ? 0 : first + 1;
    if (first < MEMORY_DATA_WIDTH) begin
      if (mode == 2'b01) begin
        mask = one << first;
      end else if (mode == 2'b10) begin
        mask = (one << first) | (one << second);
      end
    end
    return cw ^ mask;
  endfunction

  logic                         s1Valid_q, s1Valid_d;
  logic [DATA_WIDTH-1:0]        s1Data_q, s1Data_d;
  logic [ADDR_WIDTH-1:0]        s1Addr_q, s1Addr_d;
  logic [1:0]                   s1Mode_q, s1Mode_d;
  logic [POS_WIDTH-1:0]         s1Pos_q, s1Pos_d;
  logic                         wrEn_q, wrEn_d;
  logic [ADDR_WIDTH-1:0]        wrAddr_q, wrAddr_d;
  logic [MEMORY_DATA_WIDTH-1:0] encoded_q, encoded_d;
  logic [CNT_WIDTH-1:0]         wrCount_q, wrCount_d;
  logic                         s2Load;
  logic                         accept;
  logic [MEMORY_DATA_WIDTH-1:0] s1Codeword;
  logic                         unusedAddrBits;

  // S2 can take a new word when it is empty or its word leaves this cycle;
  // S1 can accept when it is empty or its word moves into S2.
  assign s2Load         = ~wrEn_q | mem_ready_i;
  assign wr_ready_o     = ~s1Valid_q | s2Load;
  assign accept         = wr_valid_i & wr_ready_o;
  assign s1Codeword     = injectErrors(encodeWord(s1Data_q), s1Mode_q, s1Pos_q);
  assign unusedAddrBits = ^{wr_addr_i[ADDR_IN_WIDTH-1:ADDR_WIDTH+2], wr_addr_i[1:0]};

  // Capture stage: a new request overwrites S1 only when S1 is free.
  always_comb begin
    s1Valid_d = s1Valid_q;
    s1Data_d  = s1Data_q;
    s1Addr_d  = s1Addr_q;
    s1Mode_d  = s1Mode_q;
    s1Pos_d   = s1Pos_q;
    if (accept) begin
      s1Valid_d = 1'b1;
      s1Data_d  = data_in;
      s1Addr_d  = wr_addr_i[ADDR_WIDTH+1:2];
      s1Mode_d  = inj_mode_i;
      s1Pos_d   = inj_pos_i;
    end else if (s2Load) begin
      s1Valid_d = 1'b0;
    end
  end

  // Output stage: holds while the memory stalls; otherwise takes S1 or empties.
  always_comb begin
    wrEn_d    = wrEn_q;
    wrAddr_d  = wrAddr_q;
    encoded_d = encoded_q;
    wrCount_d = wrCount_q;
    if (s2Load) begin
      wrEn_d = s1Valid_q;
      if (s1Valid_q) begin
        wrAddr_d  = s1Addr_q;
        encoded_d = s1Codeword;
      end
    end
    if (wrEn_q && mem_ready_i) begin
      wrCount_d = wrCount_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end
  end

  // State registers; reset discards any in-flight words.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      s1Valid_q <= 1'b0;
      s1Data_q  <= '0;
      s1Addr_q  <= '0;
      s1Mode_q  <= '0;
      s1Pos_q   <= '0;
      wrEn_q    <= 1'b0;
      wrAddr_q  <= '0;
      encoded_q <= '0;
      wrCount_q <= '0;
    end else begin
      s1Valid_q <= s1Valid_d;
      s1Data_q  <= s1Data_d;
      s1Addr_q  <= s1Addr_d;
      s1Mode_q  <= s1Mode_d;
      s1Pos_q   <= s1Pos_d;
      wrEn_q    <= wrEn_d;
      wrAddr_q  <= wrAddr_d;
      encoded_q <= encoded_d;
      wrCount_q <= wrCount_d;
    end
  end

  assign wr_en_o      = wrEn_q;
  assign wr_addr_o    = wrAddr_q;
  assign encoded_data = encoded_q;
  assign wr_count_o   = wrCount_q;

endmodule

// File: tb/tb_ecc_secded_wr_pipe.sv
// Self-checking bench for ecc_secded_wr_pipe: directed codeword and injection
// cases, backpressure, streaming, random stalls and asynchronous reset.
module tb_ecc_secded_wr_pipe;

  localparam int DW  = 32;
  localparam int PB  = 6;
  localparam int MDW = DW + PB + 1;
  localparam int AIW = 32;
  localparam int AW  = 5;
  localparam int CW  = 16;
  localparam int PW  = $clog2(MDW);

  logic           clk;
  logic           rstN;
  logic           wrValid;
  logic           wrReady;
  logic [AIW-1:0] wrAddr;
  logic [DW-1:0]  dataIn;
  logic [1:0]     injMode;
  logic [PW-1:0]  injPos;
  logic           wrEn;
  logic           memReady;
  logic [AW-1:0]  wrAddrOut;
  logic [MDW-1:0] encoded;
  logic [CW-1:0]  wrCount;

  int checks   = 0;
  int failures = 0;
  logic [MDW-1:0] expData[$];
  logic [AW-1:0]  expAddr[$];
  int refCount = 0;

  ecc_secded_wr_pipe dut (
    .clk_i        (clk),
    .rst_n_i      (rstN),
    .wr_valid_i   (wrValid),
    .wr_ready_o   (wrReady),
    .wr_addr_i    (wrAddr),
    .data_in      (dataIn),
    .inj_mode_i   (injMode),
    .inj_pos_i    (injPos),
    .wr_en_o      (wrEn),
    .mem_ready_i  (memReady),
    .wr_addr_o    (wrAddrOut),
    .encoded_data (encoded),
    .wr_count_o   (wrCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // Single point of comparison: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h", tag, actual, expected);
    end
  endtask

  // Reference codeword straight from the Hamming rules: lay out data positions,
  // compute each check bit as the parity of the covered data bits, then inject.
  function automatic logic [MDW-1:0] refEncode(input logic [DW-1:0] d, input logic [1:0] mode, input int pos);
    int dataPos[DW];
    int n;
    logic [PB-1:0] pv;
    logic ov;
    logic [MDW-1:0] cw;
    n = 0;
    for (int h = 1; h <= DW + PB; h++) begin
      if ($countones(h) != 1) begin
        if (n < DW) dataPos[n] = h;
        n++;
      end
    end
    for (int k = 1; k <= PB; k++) begin
      pv[k-1] = 1'b0;
      for (int i = 0; i < DW; i++) begin
        if (d[i] && ((dataPos[i] / (2 ** (k - 1))) % 2 == 1)) pv[k-1] = ~pv[k-1];
      end
    end
    ov = ((($countones(d) + $countones(pv)) % 2) == 1);
    cw = {pv, ov, d};
    if (pos < MDW) begin
      if (mode == 2'd1) begin
        cw[pos] = ~cw[pos];
      end else if (mode == 2'd2) begin
        cw[pos] = ~cw[pos];
        cw[(pos + 1) % MDW] = ~cw[(pos + 1) % MDW];
      end
    end
    return cw;
  endfunction

  // Scoreboard: record accepted requests and compare every word leaving to memory.
  always @(negedge clk) begin
    if (rstN) begin
      if (wrEn && memReady) begin
        if (expData.size() == 0) begin
          checkOutput("unexpected_word", 64'(wrEn), 64'd0);
        end else begin
          checkOutput("stream_data", 64'(encoded), 64'(expData.pop_front()));
          checkOutput("stream_addr", 64'(wrAddrOut), 64'(expAddr.pop_front()));
        end
        checkOutput("stream_count", 64'(wrCount), 64'(CW'(refCount)));
        refCount++;
      end
      if (wrValid && wrReady) begin
        expData.push_back(refEncode(dataIn, injMode, int'(injPos)));
        expAddr.push_back(wrAddr[AW+1:2]);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [DW-1:0] d, input logic [AIW-1:0] a,
                               input logic [1:0] m, input logic [PW-1:0] p);
    wrValid = v;
    dataIn  = d;
    wrAddr  = a;
    injMode = m;
    injPos  = p;
  endtask

  task automatic resetDut();
    rstN = 1'b0;
    applyStimulus(1'b0, '0, '0, 2'd0, '0);
    memReady = 1'b1;
    #1;
    expData.delete();
    expAddr.delete();
    refCount = 0;
    tick();
    tick();
    rstN = 1'b1;
  endtask

  task automatic waitDrain(input string tag);
    for (int c = 0; c < 40; c++) begin
      if (expData.size() == 0 && !wrEn) break;
      tick();
    end
    checkOutput(tag, 64'(expData.size()), 64'd0);
  endtask

  task automatic sendOne(input string tag, input logic [DW-1:0] d, input logic [1:0] m,
                         input logic [PW-1:0] p, input logic [MDW-1:0] expected);
    applyStimulus(1'b1, d, 32'hAB0, m, p);
    tick();
    applyStimulus(1'b0, '0, '0, 2'd0, '0);
    tick();
    checkOutput({tag, "_en"}, 64'(wrEn), 64'd1);
    checkOutput(tag, 64'(encoded), 64'(expected));
    tick();
  endtask

  logic [MDW-1:0] holdData;
  logic [AW-1:0]  holdAddr;
  int gaps;
  int stalls;
  int startCount;
  int stale;

  initial begin
    rstN = 1'b0;
    memReady = 1'b1;
    applyStimulus(1'b0, '0, '0, 2'd0, '0);
    #2;
    checkOutput("reset_wren", 64'(wrEn), 64'd0);
    checkOutput("reset_addr", 64'(wrAddrOut), 64'd0);
    checkOutput("reset_data", 64'(encoded), 64'd0);
    checkOutput("reset_count", 64'(wrCount), 64'd0);
    checkOutput("reset_ready", 64'(wrReady), 64'd1);
    tick();
    tick();
    rstN = 1'b1;

    // Single write, latency and address conversion
    applyStimulus(1'b1, 32'h0000_0001, 32'h1C, 2'd0, '0);
    #1;
    checkOutput("idle_ready", 64'(wrReady), 64'd1);
    tick();
    applyStimulus(1'b0, '0, '0, 2'd0, '0);
    checkOutput("lat_cycle1", 64'(wrEn), 64'd0);
    tick();
    checkOutput("lat_cycle2", 64'(wrEn), 64'd1);
    checkOutput("first_addr", 64'(wrAddrOut), 64'd7);
    checkOutput("first_data", 64'(encoded), 64'h07_0000_0001);
    tick();
    checkOutput("single_drop", 64'(wrEn), 64'd0);

    // Directed codewords and error injection
    sendOne("all_ones", 32'hFFFF_FFFF, 2'd0, 6'd0, 39'h30_FFFF_FFFF);
    sendOne("all_zero", 32'h0, 2'd0, 6'd0, 39'h0);
    sendOne("inj_single0", 32'h0, 2'd1, 6'd0, 39'h1);
    sendOne("inj_double_wrap", 32'h0, 2'd2, 6'd38, 39'h40_0000_0001);
    sendOne("inj_out_of_range", 32'h0, 2'd2, 6'd45, 39'h0);
    sendOne("inj_mode3", 32'h0, 2'd3, 6'd5, 39'h0);
    waitDrain("directed_drain");

    // Backpressure: two words fill the pipe, the third waits
    resetDut();
    memReady = 1'b0;
    applyStimulus(1'b1, $urandom, $urandom, 2'd0, '0);
    tick();
    applyStimulus(1'b1, $urandom, $urandom, 2'd0, '0);
    tick();
    applyStimulus(1'b1, $urandom, $urandom, 2'd0, '0);
    #1;
    checkOutput("bp_ready_low", 64'(wrReady), 64'd0);
    checkOutput("bp_wren", 64'(wrEn), 64'd1);
    holdData = encoded;
    holdAddr = wrAddrOut;
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("bp_hold_en", 64'(wrEn), 64'd1);
      checkOutput("bp_hold_data", 64'(encoded), 64'(holdData));
      checkOutput("bp_hold_addr", 64'(wrAddrOut), 64'(holdAddr));
      checkOutput("bp_hold_ready", 64'(wrReady), 64'd0);
    end
    memReady = 1'b1;
    tick();
    applyStimulus(1'b0, '0, '0, 2'd0, '0);
    waitDrain("bp_drain");
    checkOutput("bp_count", 64'(wrCount), 64'd3);

    // Streaming: back-to-back requests, one output per cycle
    memReady = 1'b1;
    gaps = 0;
    stalls = 0;
    startCount = refCount;
    for (int i = 0; i < 100; i++) begin
      applyStimulus(1'b1, $urandom, $urandom, 2'($urandom_range(0, 3)), PW'($urandom_range(0, 63)));
      #1;
      if (!wrReady) stalls++;
      tick();
      if (i > 0 && !wrEn) gaps++;
    end
    applyStimulus(1'b0, '0, '0, 2'd0, '0);
    waitDrain("stream_drain");
    checkOutput("stream_gaps", 64'(gaps), 64'd0);
    checkOutput("stream_stalls", 64'(stalls), 64'd0);
    checkOutput("stream_outputs", 64'(refCount - startCount), 64'd100);
    checkOutput("stream_total", 64'(wrCount), 64'(CW'(refCount)));

    // Random valid and memory stalls
    for (int i = 0; i < 200; i++) begin
      memReady = ($urandom_range(0, 3) != 0);
      applyStimulus(1'($urandom_range(0, 1)), $urandom, $urandom,
                    2'($urandom_range(0, 3)), PW'($urandom_range(0, 63)));
      tick();
    end
    applyStimulus(1'b0, '0, '0, 2'd0, '0);
    memReady = 1'b1;
    waitDrain("random_drain");
    checkOutput("random_total", 64'(wrCount), 64'(CW'(refCount)));

    // Asynchronous reset with both stages full
    memReady = 1'b0;
    applyStimulus(1'b1, $urandom, $urandom, 2'd0, '0);
    tick();
    applyStimulus(1'b1, $urandom, $urandom, 2'd0, '0);
    tick();
    applyStimulus(1'b0, '0, '0, 2'd0, '0);
    #1;
    checkOutput("pre_reset_full_en", 64'(wrEn), 64'd1);
    checkOutput("pre_reset_full_ready", 64'(wrReady), 64'd0);
    #2;
    rstN = 1'b0;
    #1;
    checkOutput("async_reset_en", 64'(wrEn), 64'd0);
    checkOutput("async_reset_count", 64'(wrCount), 64'd0);
    checkOutput("async_reset_data", 64'(encoded), 64'd0);
    checkOutput("async_reset_addr", 64'(wrAddrOut), 64'd0);
    expData.delete();
    expAddr.delete();
    refCount = 0;
    tick();
    memReady = 1'b1;
    rstN = 1'b1;
    stale = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (wrEn) stale++;
    end
    checkOutput("no_stale_word", 64'(stale), 64'd0);
    checkOutput("post_reset_count", 64'(wrCount), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ecc_secded_wr_pipe.md
Name: ecc_secded_wr_pipe

Overview:
- Parametrised, pipelined successor to the sync-FIFO write-path data encoder.
- Computes Hamming SECDED check bits internally from write data, so no externally supplied parity is needed.
- Converts the byte write address to a memory word address.
- Adds a valid/ready handshake with backpressure, a verification error-injection mode and a write counter.
- Sits between the FIFO write port and the ECC-protected memory array.

Parameters:
- DATA_WIDTH, 32, data bits per word.
- PARITY_BITS, 6, Hamming check bits. Constraint: 2^PARITY_BITS >= DATA_WIDTH+PARITY_BITS+1.
- MEMORY_DATA_WIDTH, DATA_WIDTH+PARITY_BITS+1, stored codeword width.
- ADDR_IN_WIDTH, 32, byte address width.
- ADDR_WIDTH, 5, memory word address width. Constraint: ADDR_WIDTH+2 <= ADDR_IN_WIDTH.
- CNT_WIDTH, 16, write counter width.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_n_i  in  1  asynchronous active-low reset.
- wr_valid_i  in  1  write request valid.
- wr_ready_o  out  1  block can accept a request.
- wr_addr_i  in  ADDR_IN_WIDTH  byte address.
- data_in  in  DATA_WIDTH  write data.
- inj_mode_i  in  2  00 none, 01 single flip, 10 double flip, 11 treated as 00.
- inj_pos_i  in  $clog2(MEMORY_DATA_WIDTH)  codeword bit to flip.
- wr_en_o  out  1  codeword valid to memory.
- mem_ready_i  in  1  memory accepts the codeword.
- wr_addr_o  out  ADDR_WIDTH  word address.
- encoded_data  out  MEMORY_DATA_WIDTH  codeword.
- wr_count_o  out  CNT_WIDTH  completed writes.

Behaviour:
- Reset: clock and reset are a single clock with asynchronous active-low reset rst_n_i. All valid flags, wr_en_o, wr_addr_o, encoded_data and wr_count_o go to 0 immediately on reset assertion. Reset mid-operation discards in-flight words.
- Pipeline: two register stages, S1 (capture) and S2 (output). Latency from an accepted handshake to wr_en_o=1 is 2 cycles when there is no backpressure. Throughput is 1 word per cycle.
- Input accept: occurs when wr_valid_i & wr_ready_o at the clock edge.
- Ready logic:
  - s2_load = ~wr_en_o | mem_ready_i.
  - wr_ready_o = ~s1_valid | s2_load.
  - The combinational path from mem_ready_i to wr_ready_o is permitted.
- S1 captures data_in, wr_addr_i[ADDR_WIDTH+1:2], inj_mode_i and inj_pos_i. Address bits [1:0] are ignored.
- S2 loads the S1 contents when s1_valid & s2_load. If s2_load=1 and s1_valid=0, wr_en_o falls to 0.
- Output hold: while wr_en_o=1 and mem_ready_i=0, wr_en_o, wr_addr_o and encoded_data are held stable.
- Encoding, computed combinationally from the S1 contents and registered into S2:
  - Hamming positions 1..DATA_WIDTH+PARITY_BITS. Check bit p[k], k=1..PARITY_BITS, occupies position 2^(k-1).
  - Data bits fill the non-power-of-two positions in ascending order, with data bit 0 at position 3.
  - p[k] = XOR of the data bits whose position has bit (k-1) set.
  - overall = XOR of all data bits and all p[k].
  - Codeword = {p[PARITY_BITS:1], overall, data}. Data sits in the low bits, which is unchanged from the current memory format.
- Error injection is applied to the computed codeword before the S2 register:
  - mode 01: flip bit inj_pos.
  - mode 10: flip bits inj_pos and (inj_pos+1) mod MEMORY_DATA_WIDTH.
  - Any inj_pos >= MEMORY_DATA_WIDTH causes no flip for that position.
- wr_count_o increments on each wr_en_o & mem_ready_i cycle. It wraps modulo 2^CNT_WIDTH.
- Simultaneous events: accept into S1 and transfer S1->S2 in the same cycle is legal. The order of words is strictly preserved.

Test Plan:
- Reset, then a single write of data 32'h0000_0001 at address 32'h1C, mem_ready_i=1 -> wr_en_o high exactly 2 cycles after accept, wr_addr_o=5'd7, encoded_data=39'h07_0000_0001.
- Write data 32'hFFFF_FFFF -> encoded_data=39'h30_FFFF_FFFF. Write data 0 -> encoded_data=0.
- Data 0 with inj_mode 01, inj_pos 0 -> encoded_data=39'h1. Same data with mode 10, pos 38 -> 39'h40_0000_0001 (wraps to bit 0). Pos 45 -> 0.
- Backpressure: mem_ready_i=0, offer 3 words -> 2 are accepted, then wr_ready_o=0 and the output is stable. Release mem_ready_i -> 3 words exit in order and wr_count_o=3.
- Streaming: 100 back-to-back writes with mem_ready_i=1 -> one output per cycle, and every codeword matches the reference model.
- Assert rst_n_i asynchronously with both stages full -> wr_en_o=0 and wr_count_o=0 before the next clock edge. No stale word appears after release.
